multi_track_sequencer: RTL and testbench

- Multi-track step sequencer and mixer; parametrised successor of the single-track 8-step note gate.
- Drives NUM_TRACKS drum voices from a NUM_STEPS pattern grid.
- Tempo and gate length are runtime inputs; per-track mute; saturating mix of all gated voices into one audio word for the codec output path.
- Sits between the per-voice sample generators and the audio codec interface; step index feeds the LED/HEX step display.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/track_gate.sv | 71 +++++++
 rtl/multi_track_sequencer.sv | 82 ++++++++
 tb/tb_multi_track_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the multi-track step sequencer.
// Holds the default widths, the per-track gate state encoding and the mix clipper.
package seq_pkg;

  localparam int unsigned AUD_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 24;

  typedef enum logic {OFF, ON} gate_state_t;

  // Clamp a wide signed sum into the signed range of an aud_w-bit word.
  // The caller keeps the low aud_w bits of the result.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] sum,
                                                  input int unsigned       aud_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (aud_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (aud_w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/track_gate.sv
// One drum voice's note gate: a two-state FSM plus a down-counter that holds
// the note on for gate_len cycles, with legato retrigger.
module track_gate
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             run,
  input  logic             step_pulse,
  input  logic             trig_bit,
  input  logic [CNT_W-1:0] gate_len,
  output logic             gate
);

  gate_state_t      state, state_n;
  logic [CNT_W-1:0] gcnt, gcnt_n;
  logic             trigger;

  assign trigger = step_pulse && trig_bit && (gate_len != '0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= OFF;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      gcnt  <= gcnt_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    if (!run) begin
      state_n = OFF;
      gcnt_n  = '0;
    end else begin
      case (state)
        OFF: begin
          if (trigger) begin
            state_n = ON;
            gcnt_n  = gate_len - CNT_W'(1);
          end
        end
        ON: begin
          if (trigger) begin
            gcnt_n = gate_len - CNT_W'(1);
          end else if (step_pulse && gate_len == '0) begin
            // A zero gate length silences held notes at the next step boundary.
            state_n = OFF;
            gcnt_n  = '0;
          end else if (gcnt == '0) begin
            state_n = OFF;
          end else begin
            gcnt_n = gcnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = OFF;
          gcnt_n  = '0;
        end
      endcase
    end
  end

  assign gate = (state == ON);

endmodule

// File: rtl/multi_track_sequencer.sv
// Multi-track step sequencer and mixer: tempo counter, step register, per-track
// note gates and a saturating mix of the gated, unmuted voices.
module multi_track_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned AUD_W      = AUD_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  localparam int unsigned STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            run,
  input  logic [CNT_W-1:0]                step_len,
  input  logic [CNT_W-1:0]                gate_len,
  input  logic [NUM_TRACKS*NUM_STEPS-1:0] pattern,
  input  logic [NUM_TRACKS-1:0]           mute,
  input  logic [NUM_TRACKS*AUD_W-1:0]     aud_in,
  output logic signed [AUD_W-1:0]         aud_out,
  output logic [STEP_W-1:0]               step,
  output logic                            step_pulse,
  output logic [NUM_TRACKS-1:0]           gate
);

  localparam int unsigned SUM_W = AUD_W + $clog2(NUM_TRACKS) + 1;

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        step_last;
  logic [NUM_TRACKS-1:0]   trig;
  logic signed [SUM_W-1:0] mix_sum;

  // A step length of zero behaves as one cycle per step.
  assign step_last  = (step_len == '0) ? '0 : step_len - CNT_W'(1);
  assign step_pulse = run && !reset && (cnt == '0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt  <= '0;
      step <= '0;
    end else if (!run) begin
      cnt  <= '0;
      step <= '0;
    end else if (cnt >= step_last) begin
      cnt  <= '0;
      step <= (step == STEP_W'(NUM_STEPS - 1)) ? '0 : step + STEP_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
    logic [NUM_STEPS-1:0] row;
    assign row     = pattern[t*NUM_STEPS +: NUM_STEPS];
    assign trig[t] = row[step];

    track_gate #(.CNT_W(CNT_W)) u_gate (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .run        (run),
      .step_pulse (step_pulse),
      .trig_bit   (trig[t]),
      .gate_len   (gate_len),
      .gate       (gate[t])
    );
  end

  // Each voice is sign-extended to the wide sum before adding.
  always_comb begin
    mix_sum = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      if (gate[t] && !mute[t])
        mix_sum = mix_sum + SUM_W'($signed(aud_in[t*AUD_W +: AUD_W]));
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) aud_out <= '0;
    else       aud_out <= AUD_W'(sat_clip(64'(mix_sum), AUD_W));
  end

endmodule

// File: tb/tb_multi_track_sequencer.sv
// Directed bench for multi_track_sequencer: 4 tracks, 8 steps, 24-bit audio.
// Cycle c=0 is the first cycle after a restart, where the step-0 pulse is seen.
module tb_multi_track_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        run;
  logic [23:0] step_len;
  logic [23:0] gate_len;
  logic [31:0] pattern;
  logic [3:0]  mute;
  logic [95:0] aud_in;
  logic [23:0] aud_out;
  logic [2:0]  step;
  logic        step_pulse;
  logic [3:0]  gate;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [95:0] AUD_NORM = {24'd4000, 24'd3000, 24'd2000, 24'd1000};

  multi_track_sequencer #(
    .NUM_TRACKS (4),
    .NUM_STEPS  (8),
    .AUD_W      (24),
    .CNT_W      (24)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .run        (run),
    .step_len   (step_len),
    .gate_len   (gate_len),
    .pattern    (pattern),
    .mute       (mute),
    .aud_in     (aud_in),
    .aud_out    (aud_out),
    .step       (step),
    .step_pulse (step_pulse),
    .gate       (gate)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    run   = 1'b0;
    tick(1);
    reset = 1'b0;
    run   = 1'b1;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    step_len = 24'd10;
    gate_len = 24'd4;
    pattern  = 32'h0;
    mute     = 4'b0000;
    aud_in   = AUD_NORM;
    tick(2);
    check("rst_step",    step,       0);
    check("rst_gate",    gate,       0);
    check("rst_aud",     aud_out,    0);
    check("rst_pulse",   step_pulse, 0);

    // Track 0 fires on every step.
    pattern = 32'h0000_00FF;
    restart();
    check("t1_pulse0",   step_pulse, 1);
    check("t1_step0",    step,       0);
    check("t1_gate_c0",  gate,       0);
    tick(1);
    check("t1_gate_c1",  gate,       4'b0001);
    check("t1_aud_c1",   aud_out,    0);
    check("t1_nopulse",  step_pulse, 0);
    tick(1);
    check("t1_aud_c2",   aud_out,    24'd1000);
    tick(2);
    check("t1_gate_c4",  gate,       4'b0001);
    tick(1);
    check("t1_gate_c5",  gate,       0);
    check("t1_aud_c5",   aud_out,    24'd1000);
    tick(1);
    check("t1_aud_c6",   aud_out,    0);
    tick(4);
    check("t1_pulse10",  step_pulse, 1);
    check("t1_step10",   step,       1);
    tick(60);
    check("t1_step70",   step,       7);
    tick(10);
    check("t1_wrap80",   step,       0);
    check("t1_pulse80",  step_pulse, 1);
    tick(2);
    check("t1_aud82",    aud_out,    24'd1000);

    // All tracks on step 3 with track 2 muted.
    pattern = 32'h0808_0808;
    mute    = 4'b0100;
    restart();
    tick(29);
    check("t2_gate29",   gate,       0);
    tick(1);
    check("t2_step30",   step,       3);
    check("t2_pulse30",  step_pulse, 1);
    tick(1);
    check("t2_gate31",   gate,       4'b1111);
    tick(1);
    check("t2_mix32",    aud_out,    24'd7000);
    tick(3);
    check("t2_gate35",   gate,       0);
    tick(1);
    check("t2_aud36",    aud_out,    0);

    // Saturation, positive then negative.
    mute   = 4'b0000;
    aud_in = {4{24'h600000}};
    restart();
    tick(32);
    check("t3_satpos",   aud_out,    24'h7FFFFF);
    aud_in = {4{24'hA00000}};
    tick(1);
    check("t3_satneg",   aud_out,    24'h800000);
    aud_in = AUD_NORM;

    // Legato: track 1 on steps 0 and 1 with a long gate.
    gate_len = 24'd15;
    pattern  = 32'h0000_0300;
    restart();
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      check("t4_legato", gate, 4'b0010);
    end
    tick(1);
    check("t4_off26",    gate,       0);

    // run dropped mid-gate at step 5, then re-asserted.
    gate_len = 24'd4;
    pattern  = 32'h0000_00FF;
    restart();
    tick(50);
    check("t5_step50",   step,       5);
    check("t5_pulse50",  step_pulse, 1);
    tick(2);
    check("t5_gate52",   gate,       4'b0001);
    check("t5_aud52",    aud_out,    24'd1000);
    run = 1'b0;
    tick(1);
    check("t5_step_rw",  step,       0);
    check("t5_gate_rw",  gate,       0);
    check("t5_aud_hold", aud_out,    24'd1000);
    tick(1);
    check("t5_aud_off",  aud_out,    0);
    run = 1'b1;
    #1;
    check("t5_repulse",  step_pulse, 1);
    check("t5_restep",   step,       0);
    tick(1);
    check("t5_regate",   gate,       4'b0001);

    // gate_len = 0 with a full pattern never sounds.
    gate_len = 24'd0;
    pattern  = 32'hFFFF_FFFF;
    restart();
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      check("t6_gate0",  gate,    0);
      check("t6_aud0",   aud_out, 0);
    end

    // gate_len forced to 0 while a note is held drops it at the next pulse.
    gate_len = 24'd15;
    pattern  = 32'h0000_0001;
    restart();
    tick(5);
    gate_len = 24'd0;
    tick(5);
    check("t6_hold10",   gate,       4'b0001);
    tick(1);
    check("t6_drop11",   gate,       0);

    // step_len shortened mid-step ends the step on the next cycle.
    gate_len = 24'd4;
    pattern  = 32'h0;
    step_len = 24'd10;
    restart();
    tick(5);
    step_len = 24'd3;
    tick(1);
    check("t6_short_st", step,       1);
    check("t6_short_pl", step_pulse, 1);
    tick(3);
    check("t6_short_p3", step,       2);

    // step_len = 0 advances every cycle.
    step_len = 24'd0;
    restart();
    check("t6_sl0_s0",   step,       0);
    tick(1);
    check("t6_sl0_s1",   step,       1);
    check("t6_sl0_pl",   step_pulse, 1);
    tick(1);
    check("t6_sl0_s2",   step,       2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
